// File: rtl/key_schedule.sv
// key_schedule: AES-128 round-key generator streaming keys 0..10 over a valid/ready handshake.
// Optional round-key store enabled by defining KEY_SCHEDULE_STORE_EN.
module key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         store_valid
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by the current round; yields the constant for round+1.
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    state_t       state;
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic [127:0] next_key;
    logic         accept, advance, last;

    assign key_ready = state == IDLE;
    assign rk_valid  = state == EMIT;
    assign accept    = key_ready && key_valid;
    assign last      = rk_index == 4'd10;
    assign advance   = rk_valid && rk_ready && !last;

    assign {w0, w1, w2, w3} = rk_out;
    assign rcon = rk_index < 4'd10 ? RCON[rk_index] : 8'h00;
    assign t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rk_out   <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state    <= EMIT;
                rk_out   <= key_in;
                rk_index <= '0;
            end else if (advance) begin
                rk_out   <= next_key;
                rk_index <= rk_index + 4'd1;
            end else if (rk_valid && rk_ready) begin
                state <= IDLE;
                done  <= 1'b1;
            end
        end
    end

`ifdef KEY_SCHEDULE_STORE_EN
    logic [127:0] store [0:10];

    always_ff @(posedge clk) begin
        if (accept)
            store[0] <= key_in;
        else if (advance)
            store[rk_index + 4'd1] <= next_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            store_valid <= 1'b0;
        else if (accept)
            store_valid <= 1'b0;
        else if (rk_valid && rk_ready && last)
            store_valid <= 1'b1;
    end

    assign rd_key = rd_idx <= 4'd10 ? store[rd_idx] : '0;
`else
    logic unused_rd_idx;

    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
    assign store_valid   = 1'b0;
`endif
endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have no parameters; fixed AES-128 (128-bit key, 11 round keys, indices 0..10).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_in  input  128  cipher key; bit 127 = byte 0; word w0 = [127:96].
REQ-005 SHALL have port key_valid  input  1  key_in offered.
REQ-006 SHALL have port key_ready  output  1  block accepts a new key.
REQ-007 SHALL have port rk_out  output  128  current round key, same byte order as key_in; feeds the round stage's key input.
REQ-008 SHALL have port rk_index  output  4  round number of rk_out, 0..10.
REQ-009 SHALL have port rk_valid  output  1  rk_out/rk_index valid.
REQ-010 SHALL have port rk_ready  input  1  consumer accepts rk_out.
REQ-011 SHALL have port done  output  1  one-cycle pulse when round key 10 is accepted.
REQ-012 SHALL have port rd_idx  input  4  stored-key read index (KEY_SCHEDULE_STORE_EN only).
REQ-013 SHALL have port rd_key  output  128  stored round key at rd_idx.
REQ-014 SHALL have port store_valid  output  1  all 11 keys held in store.

Function
REQ-015 SHALL implement states IDLE and EMIT; key_ready = 1 exactly in IDLE; rk_valid = 1 exactly in EMIT.
REQ-016 IDLE: key_valid & key_ready at edge N -> EMIT at N+1, rk_out = key_in, rk_index = 0.
REQ-017 EMIT: handshake = rk_valid & rk_ready; rk_out, rk_index stable while rk_valid & !rk_ready.
REQ-018 EMIT handshake with rk_index < 10: next edge loads round key rk_index+1, stays in EMIT; one key per cycle when rk_ready held high.
REQ-019 EMIT handshake with rk_index = 10: next edge -> IDLE, done = 1 for that one cycle, rk_out and rk_index hold last values.
REQ-020 Next key: t = SubWord(RotWord(w3)) xor {Rcon[i],24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-021 Rcon for next index 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-022 SubWord SHALL use the standard AES forward S-box, four instances, combinational within one cycle.
REQ-023 key_valid while not in IDLE SHALL be ignored; no key is latched.
REQ-024 Complete run with rk_ready always 1 SHALL take 12 cycles from key acceptance to return to IDLE (11 EMIT cycles).

Reset
REQ-025 rst_n low SHALL immediately, asynchronously force IDLE, rk_out = 0, rk_index = 0, rk_valid = 0, done = 0, store_valid = 0.
REQ-026 Reset during EMIT SHALL abandon the schedule; first post-reset key acceptance restarts at index 0.

Configuration
REQ-027 Macro KEY_SCHEDULE_STORE_EN defined: an 11 x 128 store SHALL write each round key at the cycle it enters rk_out, at address rk_index.
REQ-028 With macro: rd_key = store[rd_idx] combinationally; rd_idx > 10 returns 0; store_valid set with done, cleared on next key acceptance or reset.
REQ-029 Without macro: no store, rd_idx ignored, rd_key = 0, store_valid = 0 constantly.

Verification
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 -> index 1 a0fafe1788542cb123a339392a6c7605, index 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after index-10 handshake.
REQ-031 Same key, rk_ready low 3 cycles at index 4 -> rk_out/rk_index stable for those cycles, final keys unchanged, 15 cycles to IDLE.
REQ-032 key_valid with a different key while at index 5 -> ignored; sequence completes with original key's values.
REQ-033 rst_n low at index 6 -> outputs zero immediately; new key 000102030405060708090a0b0c0d0e0f -> index 10 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 With KEY_SCHEDULE_STORE_EN, after REQ-030 run: rd_idx = 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, rd_idx = 12 -> 0, store_valid 1; cleared on next key acceptance.
